// File: rtl/ann_input_loader.sv
// Double-buffered input feeder for the fully connected ANN: serial words fill a shadow
// frame, complete frames swap into the active vector, and one inference is timed per frame.
module ann_input_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int INPUT_NODES    = 100,
    parameter int COMPUTE_CYCLES = 103
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [DATA_WIDTH*INPUT_NODES-1:0] input_ANN,
    output logic                              ann_reset,
    output logic                              busy,
    output logic                              result_valid
);

    localparam int FCW = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1;
    localparam int CCW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam logic [FCW-1:0] FILL_LAST = FCW'(INPUT_NODES - 1);
    localparam logic [FCW-1:0] FILL_ONE  = FCW'(1);
    localparam logic [CCW-1:0] CYC_LAST  = CCW'(COMPUTE_CYCLES - 1);
    localparam logic [CCW-1:0] CYC_ONE   = CCW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                              state_q;
    logic [DATA_WIDTH*INPUT_NODES-1:0]   shadow_q;
    logic [DATA_WIDTH*INPUT_NODES-1:0]   active_q;
    logic [FCW-1:0]                      fill_cnt_q;
    logic [FCW-1:0]                      fill_cnt_d;
    logic                                shadow_full_q;
    logic                                shadow_full_d;
    logic [CCW-1:0]                      cyc_cnt_q;
    logic                                ann_reset_q;
    logic                                busy_q;
    logic                                result_valid_q;
    logic                                accept_s;
    logic                                swap_s;

    // s_ready is 0 whenever a frame waits in the shadow, so accept and swap are exclusive
    assign s_ready      = ~shadow_full_q;
    assign accept_s     = s_valid & ~shadow_full_q;
    assign swap_s       = (state_q == IDLE) & shadow_full_q;
    assign input_ANN    = active_q;
    assign ann_reset    = ann_reset_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;

    // Fill-side next state: slot counter wraps on the last word and marks the shadow full
    always_comb begin
        fill_cnt_d    = fill_cnt_q;
        shadow_full_d = shadow_full_q;
        if (accept_s) begin
            if (fill_cnt_q == FILL_LAST) begin
                fill_cnt_d    = '0;
                shadow_full_d = 1'b1;
            end else begin
                fill_cnt_d    = fill_cnt_q + FILL_ONE;
                shadow_full_d = shadow_full_q;
            end
        end else if (swap_s) begin
            shadow_full_d = 1'b0;
        end else begin
            shadow_full_d = shadow_full_q;
        end
    end

    // Fill-side registers: shadow word write, slot counter and full flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q      <= '0;
            fill_cnt_q    <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            fill_cnt_q    <= fill_cnt_d;
            shadow_full_q <= shadow_full_d;
            if (accept_s) begin
                shadow_q[int'(fill_cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            end
        end
    end

    // Compute FSM with registered network controls; active vector only moves in IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            active_q       <= '0;
            cyc_cnt_q      <= '0;
            ann_reset_q    <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ann_reset_q    <= 1'b1;
                    result_valid_q <= 1'b0;
                    if (shadow_full_q) begin
                        active_q <= shadow_q;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                START: begin
                    cyc_cnt_q   <= '0;
                    ann_reset_q <= 1'b0;
                    busy_q      <= 1'b1;
                    state_q     <= RUN;
                end
                RUN: begin
                    if (cyc_cnt_q == CYC_LAST) begin
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cyc_cnt_q      <= cyc_cnt_q + CYC_ONE;
                    end
                end
                DONE: begin
                    result_valid_q <= 1'b0;
                    ann_reset_q    <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q        <= IDLE;
                    ann_reset_q    <= 1'b1;
                    busy_q         <= 1'b0;
                    result_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ann_input_loader.sv
// Randomized scoreboard bench for ann_input_loader: a frame-level model predicts each
// frame's active vector and the clock edge at which result_valid is captured.
module tb_ann_input_loader;

    localparam int DW = 32;
    localparam int IN = 100;
    localparam int CC = 103;

    logic               clk;
    logic               reset;
    logic [DW-1:0]      s_data;
    logic               s_valid;
    logic               s_ready;
    logic [DW*IN-1:0]   input_ANN;
    logic               ann_reset;
    logic               busy;
    logic               result_valid;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int last_r_edge = 0;
    int last_accept_edge = 0;
    bit saw_stall = 1'b0;

    logic [DW-1:0]    partial_q [$];
    logic [DW*IN-1:0] exp_vec_q [$];
    int               exp_edge_q [$];
    logic [DW-1:0]    frame_w [IN];

    ann_input_loader #(.DATA_WIDTH(DW), .INPUT_NODES(IN), .COMPUTE_CYCLES(CC)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .input_ANN    (input_ANN),
        .ann_reset    (ann_reset),
        .busy         (busy),
        .result_valid (result_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [DW*IN-1:0] act, input logic [DW*IN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < IN; k++) begin
                if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
                    $display("FAIL %s: word %0d got %0h expected %0h", nm, k,
                             act[k*DW +: DW], exp[k*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    // Reference model: a frame is 100 accepted words in order; it swaps one edge after
    // its last word or one edge after the previous result pulse, whichever is later,
    // then result_valid is captured COMPUTE_CYCLES+2 edges after the swap.
    task automatic model_accept(input logic [DW-1:0] w, input int t);
        logic [DW*IN-1:0] v;
        int swap_e;
        partial_q.push_back(w);
        last_accept_edge = t;
        if (partial_q.size() == IN) begin
            for (int k = 0; k < IN; k++) v[k*DW +: DW] = partial_q[k];
            swap_e = (t + 1 > last_r_edge + 1) ? t + 1 : last_r_edge + 1;
            last_r_edge = swap_e + CC + 2;
            exp_vec_q.push_back(v);
            exp_edge_q.push_back(last_r_edge);
            partial_q.delete();
        end
    endtask

    // mode 0: continuous, 1: s_valid toggles each cycle, 2: random gaps
    task automatic send_words(input logic [DW-1:0] w [IN], input int mode, input int n);
        bit tog = 1'b1;
        bit v;
        bit accepted;
        for (int k = 0; k < n; k++) begin
            accepted = 1'b0;
            for (int tries = 0; tries < 2000 && !accepted; tries++) begin
                @(negedge clk);
                case (mode)
                    1: begin v = tog; tog = ~tog; end
                    2: v = ($urandom_range(0, 3) != 0);
                    default: v = 1'b1;
                endcase
                s_valid = v;
                s_data  = v ? w[k] : $urandom;
                if (v && s_ready) begin
                    accepted = 1'b1;
                    model_accept(w[k], edge_cnt + 1);
                end
            end
            if (!accepted) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: word %0d never accepted", k);
                return;
            end
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_vec_q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_vec_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        partial_q.delete();
        exp_vec_q.delete();
        exp_edge_q.delete();
        last_r_edge = 0;
        repeat (n) @(negedge clk);
        chk("rst_ann_reset", 64'(ann_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk_vec("rst_input_ANN", input_ANN, '0);
        reset = 1'b1;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < IN; k++) frame_w[k] = $urandom;
    endtask

    // Monitor: every result_valid pulse must match the oldest predicted frame
    initial begin
        logic [DW*IN-1:0] ev;
        int ee;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && s_ready === 1'b0) saw_stall = 1'b1;
            if (result_valid === 1'b1) begin
                if (exp_vec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: result_valid at edge %0d with nothing expected",
                             edge_cnt + 1);
                end else begin
                    ev = exp_vec_q.pop_front();
                    ee = exp_edge_q.pop_front();
                    chk_vec("result_frame", input_ANN, ev);
                    chk("result_edge", 64'(edge_cnt + 1), 64'(ee));
                end
            end
        end
    end

    initial begin
        int t5;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;

        do_reset(3);

        for (int k = 0; k < IN; k++) frame_w[k] = DW'(k + 1);
        send_words(frame_w, 0, IN);
        idle_in();
        drain();
        chk("word0", 64'(input_ANN[31:0]), 64'd1);
        chk("word99", 64'(input_ANN[3199:3168]), 64'd100);

        send_words(frame_w, 1, IN);
        idle_in();
        drain();
        chk("gapped_word50", 64'(input_ANN[50*DW +: DW]), 64'd51);

        rand_frame();
        send_words(frame_w, 2, IN);
        idle_in();
        drain();

        saw_stall = 1'b0;
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_words(frame_w, 0, IN);
        end
        idle_in();
        drain();
        chk("b2b_stall_seen", 64'(saw_stall), 64'd1);

        rand_frame();
        send_words(frame_w, 0, IN);
        idle_in();
        t5 = last_accept_edge;
        for (int i = 0; i < 200 && edge_cnt < t5 + 51; i++) @(negedge clk);
        do_reset(1);
        repeat (120) @(negedge clk);
        rand_frame();
        send_words(frame_w, 2, IN);
        idle_in();
        drain();

        rand_frame();
        send_words(frame_w, 0, 40);
        do_reset(2);
        rand_frame();
        send_words(frame_w, 0, IN);
        idle_in();
        drain();
        chk("midfill_word0", 64'(input_ANN[31:0]), 64'(frame_w[0]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
